// File: rtl/des_pkg.sv
// Shared DES definitions: datapath widths, the eight FIPS 46-3 S-box tables,
// a lookup helper, and the S-box stage FSM state type.
// No ports; imported by the S-box stage and reused by the E, P and key-schedule stages.
package des_pkg;

    localparam int unsigned DES_HALF_W = 32;
    localparam int unsigned DES_EXP_W  = 48;

    // SBOX[box][row*16 + col]. Box 1 is the most significant 256-bit slice.
    // Within each box, entry 0 is the leftmost nibble of its literal.
    localparam logic [1:8][0:63][3:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // six = b1..b6 with b1 in six[5]; row = {b1,b6}, column = b2..b5.
    function automatic logic [3:0] sbox_lookup(input logic [3:0] box, input logic [5:0] six);
        return SBOX[box][{six[5], six[0], six[4:1]}];
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } sbox_state_e;

endpackage

// File: rtl/des_sbox_rom.sv
// Combinational DES S-box lookup.
// The box used is BOX + STRIDE*grp, so one instance walks across boxes as the
// group counter advances (STRIDE = boxes evaluated per clock).
// Ports:
//   grp  in  3  current group index
//   six  in  6  6-bit group b1..b6 (b1 in six[5])
//   nib  out 4  S-box output nibble
module des_sbox_rom
    import des_pkg::*;
#(
    parameter int unsigned BOX    = 1,
    parameter int unsigned STRIDE = 8
) (
    input  logic [2:0] grp,
    input  logic [5:0] six,
    output logic [3:0] nib
);

    logic [3:0] box;

    assign box = 4'(BOX + STRIDE * 32'(grp));
    assign nib = sbox_lookup(box, six);

endmodule

// File: rtl/des_sbox_stage.sv
// Feistel-round S-box substitution stage. Takes the 48-bit E(R) xor K word and
// produces the 32-bit S-box output, evaluating SBOX_PER_CYCLE boxes per clock.
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   x is valid
//   in_ready   out  1   stage can accept x this cycle
//   x          in   48  E(R) xor K, x[48] is DES bit 1
//   out_valid  out  1   s holds a completed result
//   out_ready  in   1   downstream accepts s
//   s          out  32  S-box output, S1 nibble in s[32:29]
//   busy       out  1   stage not idle
module des_sbox_stage
    import des_pkg::*;
#(
    parameter int unsigned SBOX_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DES_EXP_W:1]    x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DES_HALF_W:1]   s,
    output logic                  busy
);

    localparam int unsigned G     = 8 / SBOX_PER_CYCLE;
    localparam int unsigned CNT_W = (G > 1) ? $clog2(G) : 1;

    if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
        SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_spc
        $error("des_sbox_stage: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
    end

    sbox_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DES_EXP_W:1]       x_q, x_d;
    logic [DES_HALF_W:1]      acc_q, acc_d;
    logic [DES_HALF_W:1]      s_q, s_d;
    logic                     out_valid_q, out_valid_d;

    logic [2:0]               grp;
    logic [2:0]               pos [SBOX_PER_CYCLE];
    logic [5:0]               six [SBOX_PER_CYCLE];
    logic [3:0]               nib [SBOX_PER_CYCLE];
    logic [4:0]               sh  [SBOX_PER_CYCLE];
    logic [DES_HALF_W:1]      acc_new;

    assign grp = 3'(cnt_q);

    for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_box
        // 0-based box number handled by lane j in the current group.
        assign pos[j] = 3'(32'(grp) * SBOX_PER_CYCLE + j);
        assign six[j] = 6'(x_q >> (32'd42 - 32'd6 * 32'(pos[j])));
        assign sh[j]  = 5'(5'd28 - {pos[j], 2'b00});

        des_sbox_rom #(
            .BOX    (j + 1),
            .STRIDE (SBOX_PER_CYCLE)
        ) u_rom (
            .grp (grp),
            .six (six[j]),
            .nib (nib[j])
        );
    end

    // Merge this cycle's nibbles into the accumulator.
    always_comb begin
        acc_new = acc_q;
        for (int j = 0; j < int'(SBOX_PER_CYCLE); j++) begin
            acc_new = (acc_new & ~(DES_HALF_W'(4'hF) << sh[j])) |
                      (DES_HALF_W'(nib[j]) << sh[j]);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        acc_d       = acc_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = x;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_new;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(G - 1)) begin
                    s_d         = acc_new;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StHold;
                end
            end
            StHold: begin
                // Accepting a new word is only possible as the result leaves.
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        x_d     = x;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_des_sbox_stage.sv
// Self-checking bench for des_sbox_stage, one instance per SBOX_PER_CYCLE in {1,2,4,8}.
module tb_des_sbox_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rstn, iv, ordy;
    wire  [3:0]  ir, ov, bz;
    logic [48:1] xa [4];
    wire  [32:1] sa [4];

    int checks   = 0;
    int failures = 0;

    logic [255:0] tbl [8];

    typedef struct {
        logic [48:1] x;
        logic [32:1] s;
    } vec_t;
    vec_t vecs [3];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_stage #(
            .SBOX_PER_CYCLE (1 << g)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rstn[g]),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .x         (xa[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .s         (sa[g]),
            .busy      (bz[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: apply the eight S-boxes straight from row/column rules.
    function automatic logic [32:1] ref_s(input logic [48:1] xin);
        logic [32:1]  r;
        logic [5:0]   six;
        logic [255:0] t;
        int           row, col;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            six = xin[48-6*k -: 6];
            row = int'({six[5], six[0]});
            col = int'(six[4:1]);
            t   = tbl[k];
            r[32-4*k -: 4] = t[255-4*(row*16+col) -: 4];
        end
        return r;
    endfunction

    function automatic logic [48:1] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Accept one word on instance i, measure latency, check result while held.
    task automatic txn(input int i, input logic [48:1] xin, input logic [32:1] exp,
                       input string nm);
        int g;
        int cyc;
        g = 8 >> i;
        @(negedge clk);
        chk($sformatf("%s spc%0d in_ready_idle", nm, 1 << i), 64'(ir[i]), 64'd1);
        iv[i] = 1'b1;
        xa[i] = xin;
        @(posedge clk);
        @(negedge clk);
        iv[i] = 1'b0;
        xa[i] = rnd48();
        chk($sformatf("%s spc%0d busy_run", nm, 1 << i), 64'(bz[i]), 64'd1);
        cyc = 0;
        while (ov[i] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s spc%0d latency", nm, 1 << i), 64'(cyc), 64'(g));
        chk($sformatf("%s spc%0d s", nm, 1 << i), 64'(sa[i]), 64'(exp));
        chk($sformatf("%s spc%0d in_ready_hold", nm, 1 << i), 64'(ir[i]), 64'd0);
    endtask

    // Take the held result with no new input; s must be retained afterwards.
    task automatic release_out(input int i, input logic [32:1] exp);
        @(negedge clk);
        ordy[i] = 1'b1;
        #1;
        chk($sformatf("spc%0d in_ready_follows_out_ready", 1 << i), 64'(ir[i]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ordy[i] = 1'b0;
        chk($sformatf("spc%0d out_valid_after_hs", 1 << i), 64'(ov[i]), 64'd0);
        chk($sformatf("spc%0d busy_after_hs", 1 << i), 64'(bz[i]), 64'd0);
        chk($sformatf("spc%0d s_retained", 1 << i), 64'(sa[i]), 64'(exp));
    endtask

    task automatic hold_test(input int i);
        logic [32:1] held;
        int          g;
        int          cyc;
        g    = 8 >> i;
        held = ref_s(48'h6117BA866527);
        txn(i, 48'h6117BA866527, held, "hold_pre");
        repeat (5) begin
            @(negedge clk);
            iv[i] = 1'b1;
            xa[i] = rnd48();
            #1;
            chk($sformatf("hold spc%0d s_stable", 1 << i), 64'(sa[i]), 64'(held));
            chk($sformatf("hold spc%0d out_valid", 1 << i), 64'(ov[i]), 64'd1);
            chk($sformatf("hold spc%0d in_ready", 1 << i), 64'(ir[i]), 64'd0);
        end
        @(negedge clk);
        ordy[i] = 1'b1;
        iv[i]   = 1'b1;
        xa[i]   = 48'h0;
        #1;
        chk($sformatf("hold spc%0d in_ready_on_release", 1 << i), 64'(ir[i]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ordy[i] = 1'b0;
        iv[i]   = 1'b0;
        xa[i]   = rnd48();
        chk($sformatf("hold spc%0d out_valid_b2b", 1 << i), 64'(ov[i]), 64'd0);
        chk($sformatf("hold spc%0d busy_b2b", 1 << i), 64'(bz[i]), 64'd1);
        cyc = 0;
        while (ov[i] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("hold spc%0d b2b_latency", 1 << i), 64'(cyc), 64'(g));
        chk($sformatf("hold spc%0d b2b_s", 1 << i), 64'(sa[i]), 64'h00000000EFA72C4D);
        release_out(i, 32'hEFA72C4D);
    endtask

    task automatic stream_test(input int i);
        logic [32:1] exp_q [$];
        logic [32:1] e;
        logic [48:1] cur;
        int          sent;
        int          got;
        int          cyc;
        bit          took;
        sent = 0;
        got  = 0;
        cyc  = 0;
        took = 0;
        cur  = rnd48();
        while ((sent < 16 || got < 16) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (took) begin
                iv[i] = 1'b0;
                took  = 0;
            end
            if (!iv[i]) begin
                xa[i] = rnd48();
                if (sent < 16 && $urandom_range(0, 1) == 1) begin
                    iv[i] = 1'b1;
                    xa[i] = cur;
                end
            end
            ordy[i] = 1'($urandom_range(0, 1));
            #1;
            if (ov[i] && ordy[i]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("stream spc%0d unexpected_output", 1 << i), 64'(sa[i]), 64'hX);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream spc%0d word%0d", 1 << i, got), 64'(sa[i]), 64'(e));
                end
                got++;
            end
            if (iv[i] && ir[i]) begin
                exp_q.push_back(ref_s(xa[i]));
                sent++;
                took = 1;
                cur  = rnd48();
            end
            @(posedge clk);
        end
        @(negedge clk);
        iv[i]   = 1'b0;
        ordy[i] = 1'b0;
        chk($sformatf("stream spc%0d sent", 1 << i), 64'(sent), 64'd16);
        chk($sformatf("stream spc%0d received", 1 << i), 64'(got), 64'd16);
        chk($sformatf("stream spc%0d leftover", 1 << i), 64'(exp_q.size()), 64'd0);
        chk($sformatf("stream spc%0d idle_after", 1 << i), 64'(bz[i]), 64'd0);
    endtask

    task automatic reset_test();
        @(negedge clk);
        iv[0] = 1'b1;
        xa[0] = 48'h6117BA866527;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst pre_busy", 64'(bz[0]), 64'd1);
        chk("rst pre_s_nonzero", 64'(sa[0] != 32'h0), 64'd1);
        #2;
        rstn[0] = 1'b0;
        #1;
        chk("rst out_valid", 64'(ov[0]), 64'd0);
        chk("rst s", 64'(sa[0]), 64'd0);
        chk("rst busy", 64'(bz[0]), 64'd0);
        @(negedge clk);
        #2;
        rstn[0] = 1'b1;
        #1;
        chk("rst in_ready_after", 64'(ir[0]), 64'd1);
        txn(0, 48'h0, 32'hEFA72C4D, "post_rst");
        release_out(0, 32'hEFA72C4D);
    endtask

    initial begin
        rstn = 4'h0;
        iv   = 4'h0;
        ordy = 4'h0;
        for (int i = 0; i < 4; i++) xa[i] = '0;
        tbl[0] = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
        tbl[1] = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
        tbl[2] = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
        tbl[3] = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
        tbl[4] = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
        tbl[5] = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
        tbl[6] = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
        tbl[7] = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
        vecs[0] = '{x: 48'h000000000000, s: 32'hEFA72C4D};
        vecs[1] = '{x: 48'hFFFFFFFFFFFF, s: 32'hD9CE3DCB};
        vecs[2] = '{x: 48'h6117BA866527, s: 32'h5C82B597};

        #12;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset spc%0d out_valid", 1 << i), 64'(ov[i]), 64'd0);
            chk($sformatf("reset spc%0d s", 1 << i), 64'(sa[i]), 64'd0);
            chk($sformatf("reset spc%0d busy", 1 << i), 64'(bz[i]), 64'd0);
        end
        rstn = 4'hF;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset spc%0d in_ready", 1 << i), 64'(ir[i]), 64'd1);
        end

        for (int i = 0; i < 4; i++) begin
            for (int v = 0; v < 3; v++) begin
                txn(i, vecs[v].x, vecs[v].s, $sformatf("vec%0d", v));
                chk($sformatf("vec%0d spc%0d model", v, 1 << i),
                    64'(ref_s(vecs[v].x)), 64'(vecs[v].s));
                release_out(i, vecs[v].s);
            end
            hold_test(i);
            stream_test(i);
        end

        reset_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
